// File: rtl/ram_n.sv
// ram_n: parametrised single-port word memory with a hardware clear sweep.
// Reads are combinational and gated by ready; writes happen on the rising
// edge. A two-state sequencer (IDLE/CLEAR) zeroes every word after reset
// (optionally) or when clear is requested. During a sweep, load and clear
// are ignored.
module ram_n #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic [$clog2(DEPTH)-1:0]   address,
    input  logic                       clear,
    output logic [WIDTH-1:0]           out,
    output logic                       ready
);

    localparam int ADDR_W = $clog2(DEPTH);

    // Last word of the sweep; reaching it ends the CLEAR state.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // With CLEAR_ON_RESET=0 the array keeps whatever it powered up with.
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   w_clr_ptr_nxt;

    logic                w_ready;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [WIDTH-1:0]    w_mem_din;

    // The storage array has no reset so it still maps onto RAM.
    logic [WIDTH-1:0]    r_mem [DEPTH];

    // State register: async reset restarts the sequencer from word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RESET_STATE;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // Next-state logic: a clear request wins over load in IDLE; a sweep
    // runs to completion and ignores further clear requests.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        unique case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            S_CLEAR: begin
                // The pointer wraps to 0 on the final word, which is harmless
                // because the state leaves CLEAR on that same edge.
                w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                if (r_clr_ptr == LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = RESET_STATE;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Output logic: ready follows the registered state; the write port is
    // steered either to the sweep pointer (writing zero) or to the user.
    always_comb begin
        w_ready    = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = address;
        w_mem_din  = in;
        unique case (r_state)
            S_IDLE: begin
                w_ready  = 1'b1;
                w_mem_we = load & ~clear;
            end
            S_CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_ptr;
                w_mem_din  = '0;
            end
            default: begin
                w_ready  = 1'b0;
                w_mem_we = 1'b0;
            end
        endcase
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    assign ready = w_ready;

    // Read port: asynchronous read, forced to zero while the array is not
    // usable so stale data never leaks during a sweep.
    assign out = w_ready ? r_mem[address] : '0;

endmodule

// File: tb/tb_ram_n.sv
// tb_ram_n: self-checking bench for ram_n, default instance (16x8, clear on
// reset) and a 32x64 instance without clear on reset.
module tb_ram_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        a_reset, a_load, a_clear;
    logic [15:0] a_in;
    logic [2:0]  a_addr;
    logic [15:0] a_out;
    logic        a_ready;

    // Wide/deep instance, no clear on reset
    logic        b_reset, b_load, b_clear;
    logic [31:0] b_in;
    logic [5:0]  b_addr;
    logic [31:0] b_out;
    logic        b_ready;

    ram_n u_dut_a (
        .clk     (clk),
        .reset   (a_reset),
        .in      (a_in),
        .load    (a_load),
        .address (a_addr),
        .clear   (a_clear),
        .out     (a_out),
        .ready   (a_ready)
    );

    ram_n #(
        .WIDTH          (32),
        .DEPTH          (64),
        .CLEAR_ON_RESET (1'b0)
    ) u_dut_b (
        .clk     (clk),
        .reset   (b_reset),
        .in      (b_in),
        .load    (b_load),
        .address (b_addr),
        .clear   (b_clear),
        .out     (b_out),
        .ready   (b_ready)
    );

    typedef struct {
        logic        ld;
        logic [2:0]  addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[16];
    logic [15:0] model[8];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected value and compare it with the current output.
    task automatic check_sb_a(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %h, expected a queued value", name, a_out);
        end else begin
            e = exp_q.pop_front();
            check(name, {16'h0, a_out}, e);
        end
    endtask

    // Read every word of instance A and compare against the model.
    task automatic readback_a(input string name);
        for (int k = 0; k < 8; k++) begin
            a_addr = k[2:0];
            exp_q.push_back({16'h0, model[k]});
            #1;
            check_sb_a(name);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 8; k++) begin
            tbl[k]     = '{ld: 1'b1, addr: k[2:0], din: 16'(k * 16'h1111), exp: 16'(k * 16'h1111)};
            tbl[8 + k] = '{ld: 1'b0, addr: k[2:0], din: 16'h0000,          exp: 16'(k * 16'h1111)};
        end
        for (int k = 0; k < 8; k++) model[k] = 16'h0000;

        a_reset = 1'b1; a_load = 1'b1; a_in = 16'hFFFF; a_clear = 1'b0; a_addr = '0;
        b_reset = 1'b1; b_load = 1'b0; b_in = '0;       b_clear = 1'b0; b_addr = '0;
        #1;
        check("a_reset_ready", {31'h0, a_ready}, 32'h0);
        check("a_reset_out", {16'h0, a_out}, 32'h0);
        check("b_reset_ready", {31'h0, b_ready}, 32'h1);
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset sweep with load held high: ready rises after exactly 8 edges
        for (int e = 1; e <= 8; e++) begin
            tick();
            a_addr = e[2:0];
            check($sformatf("sweep_ready_e%0d", e), {31'h0, a_ready}, (e == 8) ? 32'h1 : 32'h0);
        end
        a_load = 1'b0;
        readback_a("sweep_zero");

        // Single write and hold, including read-during-write
        tick();
        a_addr = 3'd2; a_in = 16'h1234; a_load = 1'b1;
        #1;
        check("rdw_old", {16'h0, a_out}, 32'h0);
        tick();
        a_load = 1'b0; a_in = 16'h0000;
        model[2] = 16'h1234;
        #1;
        check("rdw_new", {16'h0, a_out}, 32'h1234);
        a_addr = 3'd3;
        #1;
        check("neighbour_untouched", {16'h0, a_out}, 32'h0);

        // Fill and readback from the vector table
        for (int i = 0; i < 16; i++) begin
            tick();
            a_addr = tbl[i].addr; a_in = tbl[i].din; a_load = tbl[i].ld;
            exp_q.push_back({16'h0, tbl[i].exp});
            if (tbl[i].ld) begin
                tick();
                model[tbl[i].addr] = tbl[i].din;
            end
            a_load = 1'b0;
            #1;
            check_sb_a($sformatf("table_%0d", i));
        end
        a_addr = 3'd7;
        #1;
        check("fill_addr7", {16'h0, a_out}, 32'h7777);

        // Clear priority over load, and clear ignored during the sweep
        tick();
        a_clear = 1'b1; a_load = 1'b1; a_addr = 3'd5; a_in = 16'hABCD;
        tick();
        a_clear = 1'b0; a_in = 16'hFFFF;
        #1;
        check("clr_start_ready", {31'h0, a_ready}, 32'h0);
        for (int e = 1; e <= 8; e++) begin
            a_clear = (e >= 2 && e <= 7);
            tick();
            check($sformatf("clr_ready_e%0d", e), {31'h0, a_ready}, (e == 8) ? 32'h1 : 32'h0);
        end
        a_clear = 1'b0; a_load = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 16'h0000;
        a_addr = 3'd5;
        #1;
        check("clr_addr5", {16'h0, a_out}, 32'h0);
        readback_a("clr_zero");

        // Asynchronous reset drops ready with no clock edge
        tick();
        a_addr = 3'd1; a_in = 16'h5A5A; a_load = 1'b1;
        tick();
        a_load = 1'b0;
        #1;
        check("pre_rst_word", {16'h0, a_out}, 32'h5A5A);
        #1;
        a_reset = 1'b1;
        #1;
        check("async_rst_ready", {31'h0, a_ready}, 32'h0);
        check("async_rst_out", {16'h0, a_out}, 32'h0);
        #1;
        a_reset = 1'b0;

        // Reset mid-sweep at clr_ptr=4 restarts the full sweep
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("mid_ready_e%0d", e), {31'h0, a_ready}, 32'h0);
        end
        #2;
        a_reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'h0, a_ready}, 32'h0);
        #1;
        a_reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("restart_ready_e%0d", e), {31'h0, a_ready}, (e == 8) ? 32'h1 : 32'h0);
        end
        a_addr = 3'd1;
        #1;
        check("restart_word1", {16'h0, a_out}, 32'h0);

        // Parameter variant: 32x64, ready straight after reset
        tick();
        check("b_ready_after_rst", {31'h0, b_ready}, 32'h1);
        b_addr = 6'd63; b_in = 32'hDEADBEEF; b_load = 1'b1;
        tick();
        b_addr = 6'd0; b_in = 32'h01234567;
        #1;
        check("b_word63_other_addr", {31'h0, b_ready}, 32'h1);
        tick();
        b_load = 1'b0;
        #1;
        check("b_word0", b_out, 32'h01234567);
        b_addr = 6'd63;
        #1;
        check("b_word63", b_out, 32'hDEADBEEF);
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        #1;
        check("b_clr_start_ready", {31'h0, b_ready}, 32'h0);
        for (int e = 1; e <= 64; e++) begin
            tick();
            check($sformatf("b_clr_ready_e%0d", e), {31'h0, b_ready}, (e == 64) ? 32'h1 : 32'h0);
        end
        #1;
        check("b_word63_cleared", b_out, 32'h0);
        b_addr = 6'd0;
        #1;
        check("b_word0_cleared", b_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_n.md
# ram_n

Parametrised successor to the fixed 8-word, 16-bit Hack-style RAM. Adds configurable word width and depth, an asynchronous active-high reset, and a hardware clear sequencer that zeroes every word after reset or on request. A `ready` flag reports when the array is usable. Intended as the generic memory primitive from which the larger RAM tiers of the CPU data memory are built.

## Interface
- `WIDTH`, 16, data word width in bits (≥1).
- `DEPTH`, 8, number of words; power of two, ≥2.
- `CLEAR_ON_RESET`, 1, whether reset starts a clear sweep.
  - 1: reset starts a clear sweep.
  - 0: reset goes straight to ready; array contents are not cleared.
- `ADDR_W`: derived localparam, not overridable; equals $clog2(DEPTH).

Ports:
- `clk`, input, 1, rising-edge clock; the only clock.
- `reset`, input, 1, asynchronous, active-high.
- `in`, input, WIDTH, write data.
- `load`, input, 1, write enable.
- `address`, input, ADDR_W, read/write address.
- `clear`, input, 1, synchronous request to zero the whole array.
- `out`, output, WIDTH, read data.
- `ready`, output, 1, high when the array accepts writes and `out` is valid.

## Operation
- The state machine has two states, IDLE and CLEAR. A clear pointer `clr_ptr` is ADDR_W bits wide.
- **Reset asserted (asynchronous):**
  - With CLEAR_ON_RESET=1: state=CLEAR, `clr_ptr`=0, `ready`=0.
  - With CLEAR_ON_RESET=0: state=IDLE, `ready`=1.
  - The memory array itself has no asynchronous reset, so that it still infers as RAM.
- **CLEAR state:** each rising edge writes 0 to `mem[clr_ptr]` and increments `clr_ptr`.
  - On the edge that clears word DEPTH-1, state goes to IDLE and `ready` is set to 1.
  - `load` and `clear` are ignored in CLEAR. A `clear` during a sweep does not restart it.
- **IDLE state:**
  - `clear`=1 takes priority. On the next edge: state=CLEAR, `clr_ptr`=0, `ready`=0. A `load` in the same cycle is dropped.
  - Otherwise `load`=1 writes `in` to `mem[address]` on the rising edge.
  - `load`=0 leaves memory unchanged.
- **Read path:**
  - `out` = `mem[address]` combinationally while `ready`=1.
  - `out` = 0 while `ready`=0.
- **Address range:** all addresses are in range because DEPTH is a power of two. `clr_ptr` wraps to 0 after DEPTH-1; this wrap is unobservable because the state leaves CLEAR on that edge.
- **Reset mid-sweep:** the sweep restarts from word 0, and `ready` stays 0 throughout.

## Timing
- **Reset values:**
  - `out`=0 for any CLEAR_ON_RESET setting.
  - `ready`=0 when CLEAR_ON_RESET=1; `ready`=1 when CLEAR_ON_RESET=0.
  - With CLEAR_ON_RESET=0, `out` shows `mem[address]` as soon as reset deasserts, contents undefined.
- **Reset assertion:** `ready` falls without waiting for a clock edge.
- **Clear duration:** exactly DEPTH rising edges after reset deassertion, or after the edge that samples `clear`. `ready` is registered and is high immediately after the DEPTH-th edge.
- **Write visibility:** a write at edge N is visible on `out` right after edge N, provided `address` is unchanged. There are no extra cycles of read latency.
- **Read-during-write:** while `load`=1 at the same address, `out` shows the old value before the edge and the new value after it.
- **Reset release:** reset deassertion is assumed synchronous to `clk` at the system level. The block does not synchronise it.

## Test plan
- **Reset sweep:** defaults; pulse `reset`; hold `load`=1, `in`=16'hFFFF during the sweep -> `ready`=0 for exactly 8 edges and 1 after the 8th; addresses 0..7 all read 16'h0000.
- **Single write and hold:** after ready, write 16'h1234 at address 3'b010; next cycle `load`=0, `in`=16'h0000 -> address 2 reads 16'h1234 and address 3 reads 16'h0000.
- **Fill and readback:** write address k with k×16'h1111 for k=0..7 -> each address reads back its value; address 7 reads 16'h7777.
- **Clear priority:** in IDLE, assert `clear`=1 together with `load`=1, address 5, `in`=16'hABCD -> `ready` low for 8 edges; address 5 then reads 16'h0000 and all previously written words read 0.
- **Reset mid-sweep:** during a sweep at `clr_ptr`=4, assert `reset` between edges -> `ready` stays 0 with no clock edge; after deassertion, `ready` rises only after 8 further edges.
- **Parameter variant:** WIDTH=32, DEPTH=64, CLEAR_ON_RESET=0 -> `ready`=1 immediately after reset; write 32'hDEADBEEF at address 63 and read it back; `clear` then gives `ready` low for exactly 64 edges.
